// File: rtl/fir_sched_pkg.sv
// Shared types and the round-robin search used by the FIR engine scheduler.
package fir_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  localparam int NCHAN_MAX = 8;

  // Returns {found, index} of the first pending channel after last_grant, wrapping at nchan.
  function automatic logic [3:0] rr_next(input logic [NCHAN_MAX-1:0] pending,
                                         input logic [2:0] last_grant,
                                         input int nchan);
    logic [3:0] res;
    int idx;
    res = '0;
    for (int k = NCHAN_MAX; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= nchan) idx = idx - nchan;
      if (k <= nchan && pending[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_iq_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the next pending channel after last_grant.
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int NCHAN = 4
) (
  input  logic [NCHAN-1:0]         pending,
  input  logic [$clog2(NCHAN)-1:0] last_grant,
  output logic [$clog2(NCHAN)-1:0] grant,
  output logic                     grant_valid
);

  localparam int CW = $clog2(NCHAN);

  logic [NCHAN_MAX-1:0] pend_ext;
  logic [2:0]           last_ext;
  logic [3:0]           pick;

  always_comb begin
    pend_ext = '0;
    pend_ext[NCHAN-1:0] = pending;
    last_ext = '0;
    last_ext[CW-1:0] = last_grant;
    pick = rr_next(pend_ext, last_ext, NCHAN);
    grant = pick[CW-1:0];
    grant_valid = pick[3];
  end

endmodule

// File: rtl/fir_iq_sched.sv
// Round-robin scheduler sharing one sequential I/Q FIR MAC engine among NCHAN channels.
module fir_iq_sched
  import fir_sched_pkg::*;
#(
  parameter int NCHAN    = 4,
  parameter int WIDTH    = 24,
  parameter int MAX_WAIT = 64
) (
  input  logic                     adc_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NCHAN-1:0]         req_strobe,
  input  logic [NCHAN*WIDTH-1:0]   req_data_i,
  input  logic [NCHAN*WIDTH-1:0]   req_data_q,
  output logic                     eng_start,
  output logic [WIDTH-1:0]         eng_data_i,
  output logic [WIDTH-1:0]         eng_data_q,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_res_i,
  input  logic [WIDTH-1:0]         eng_res_q,
  output logic [NCHAN-1:0]         out_strobe,
  output logic [WIDTH-1:0]         out_data_i,
  output logic [WIDTH-1:0]         out_data_q,
  output logic [$clog2(NCHAN)-1:0] out_chan,
  output logic [NCHAN-1:0]         overrun,
  output logic                     timeout,
  input  logic                     flags_clr
);

  localparam int CW = $clog2(NCHAN);
  localparam int TW = $clog2(MAX_WAIT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(MAX_WAIT - 1);
  localparam logic [TW-1:0] WAIT_MAX  = TW'(MAX_WAIT);

  state_t state, state_nxt;
  logic [NCHAN-1:0]        pending;
  logic signed [WIDTH-1:0] hold_i [NCHAN];
  logic signed [WIDTH-1:0] hold_q [NCHAN];
  logic [CW-1:0]           grant, last_grant, arb_grant;
  logic                    arb_valid;
  logic [TW-1:0]           wait_cnt;
  logic                    timeout_evt;
  logic [NCHAN-1:0]        issue_mask, ovr_evt;
  logic                    done_p0;
  logic signed [WIDTH-1:0] res_i_p0, res_q_p0;

  rr_arbiter #(.NCHAN(NCHAN)) u_arb (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_valid(arb_valid)
  );

  assign issue_mask = (state == ISSUE) ? (NCHAN'(1) << grant) : '0;
  // A strobe on the channel being issued refills it without overrun: its old sample is consumed.
  assign ovr_evt    = enable ? (req_strobe & pending & ~issue_mask) : '0;

  assign eng_start  = (state == ISSUE);
  assign eng_data_i = eng_start ? hold_i[grant] : '0;
  assign eng_data_q = eng_start ? hold_q[grant] : '0;
  assign out_strobe = (state == DELIVER) ? (NCHAN'(1) << grant) : '0;

  always_comb begin
    state_nxt   = state;
    timeout_evt = 1'b0;
    case (state)
      IDLE:    if (arb_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (done_p0) begin
          state_nxt = DELIVER;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = IDLE;
          timeout_evt = 1'b1;
        end
      end
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt   = IDLE;
      timeout_evt = 1'b0;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      grant      <= '0;
      last_grant <= CW'(NCHAN - 1);
      wait_cnt   <= '0;
      done_p0    <= 1'b0;
      overrun    <= '0;
      timeout    <= 1'b0;
      out_data_i <= '0;
      out_data_q <= '0;
      out_chan   <= '0;
    end else begin
      state   <= state_nxt;
      done_p0 <= eng_done && (state == WAIT) && enable;
      pending <= enable ? ((pending & ~issue_mask) | req_strobe) : '0;
      overrun <= (overrun & ~{NCHAN{flags_clr}}) | ovr_evt;
      timeout <= (timeout & ~flags_clr) | timeout_evt;
      if (state == IDLE && state_nxt == ISSUE) begin
        grant      <= arb_grant;
        last_grant <= arb_grant;
      end
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT && wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == WAIT && state_nxt == DELIVER) begin
        out_data_i <= res_i_p0;
        out_data_q <= res_q_p0;
        out_chan   <= grant;
      end
    end
  end

  // Data path: sample holds and the engine-result stage carry no reset.
  always_ff @(posedge adc_clk) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (enable && req_strobe[c]) begin
        hold_i[c] <= req_data_i[c*WIDTH +: WIDTH];
        hold_q[c] <= req_data_q[c*WIDTH +: WIDTH];
      end
    end
    res_i_p0 <= eng_res_i;
    res_q_p0 <= eng_res_q;
  end

endmodule

// File: tb/tb_fir_iq_sched.sv
// Self-checking bench for fir_iq_sched with an echoing FIR engine model.
module tb_fir_iq_sched;

  localparam int NCHAN = 4;
  localparam int WIDTH = 24;
  localparam int MAX_WAIT = 64;

  logic adc_clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic [NCHAN-1:0] req_strobe = '0;
  logic [NCHAN*WIDTH-1:0] req_data_i = '0, req_data_q = '0;
  logic eng_start;
  logic [WIDTH-1:0] eng_data_i, eng_data_q;
  logic eng_done;
  logic [WIDTH-1:0] eng_res_i, eng_res_q;
  logic [NCHAN-1:0] out_strobe;
  logic [WIDTH-1:0] out_data_i, out_data_q;
  logic [1:0] out_chan;
  logic [NCHAN-1:0] overrun;
  logic timeout;
  logic flags_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fir_iq_sched #(.NCHAN(NCHAN), .WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .adc_clk(adc_clk), .reset(reset), .enable(enable), .req_strobe(req_strobe),
    .req_data_i(req_data_i), .req_data_q(req_data_q), .eng_start(eng_start),
    .eng_data_i(eng_data_i), .eng_data_q(eng_data_q), .eng_done(eng_done),
    .eng_res_i(eng_res_i), .eng_res_q(eng_res_q), .out_strobe(out_strobe),
    .out_data_i(out_data_i), .out_data_q(out_data_q), .out_chan(out_chan),
    .overrun(overrun), .timeout(timeout), .flags_clr(flags_clr)
  );

  always #5 adc_clk = ~adc_clk;
  always @(posedge adc_clk) cyc <= cyc + 1;

  // Engine model: echoes the issued sample eng_lat cycles after eng_start.
  int eng_lat = 18;
  logic eng_echo = 1'b1;
  logic eng_flush = 1'b0;
  int done_cyc = 0;
  initial begin
    int cnt;
    logic [WIDTH-1:0] cap_i, cap_q;
    cnt = 0; cap_i = '0; cap_q = '0;
    eng_done = 1'b0; eng_res_i = '0; eng_res_q = '0;
    forever begin
      @(negedge adc_clk);
      eng_done = 1'b0;
      if (eng_flush) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1; eng_res_i = cap_i; eng_res_q = cap_q; done_cyc = cyc;
        end
      end
      if (eng_start && eng_echo) begin
        cnt = eng_lat; cap_i = eng_data_i; cap_q = eng_data_q;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input logic flush);
    @(negedge adc_clk);
    reset = 1'b1; enable = 1'b1; req_strobe = '0; flags_clr = 1'b0; eng_flush = flush;
    @(negedge adc_clk);
    @(negedge adc_clk);
    reset = 1'b0; eng_flush = 1'b0;
  endtask

  task automatic set_data(input int c, input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dq);
    req_data_i[c*WIDTH +: WIDTH] = di;
    req_data_q[c*WIDTH +: WIDTH] = dq;
  endtask

  task automatic wait_out(input string name, input int budget, output int fc);
    fc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge adc_clk);
      if (out_strobe != '0) begin fc = cyc; break; end
    end
    if (fc < 0) begin
      checks++; errors++;
      $display("FAIL %s: no out_strobe within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_start(input string name, input int budget, output int sc);
    sc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge adc_clk);
      if (eng_start) begin sc = cyc; break; end
    end
    if (sc < 0) begin
      checks++; errors++;
      $display("FAIL %s: no eng_start within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_clr();
    flags_clr = 1'b1;
    @(negedge adc_clk);
    flags_clr = 1'b0;
  endtask

  // Reference model: burst of simultaneous requests served in rotation after rr_last.
  int rr_last = NCHAN - 1;
  task automatic run_burst(input logic [NCHAN-1:0] mask, input logic [NCHAN-1:0] remask, input int lat);
    logic [WIDTH-1:0] vi [NCHAN];
    logic [WIDTH-1:0] vq [NCHAN];
    int order[$];
    int fc, ch;
    eng_lat = lat;
    for (int c = 0; c < NCHAN; c++) begin
      vi[c] = WIDTH'($urandom); vq[c] = WIDTH'($urandom); set_data(c, vi[c], vq[c]);
    end
    req_strobe = mask;
    @(negedge adc_clk);
    req_strobe = '0;
    if (remask != '0) begin
      for (int c = 0; c < NCHAN; c++) if (remask[c]) begin
        vi[c] = WIDTH'($urandom); vq[c] = WIDTH'($urandom); set_data(c, vi[c], vq[c]);
      end
      req_strobe = remask;
      @(negedge adc_clk);
      req_strobe = '0;
    end
    for (int k = 1; k <= NCHAN; k++) begin
      ch = (rr_last + k) % NCHAN;
      if (mask[ch]) order.push_back(ch);
    end
    rr_last = order[order.size()-1];
    foreach (order[j]) begin
      wait_out("burst_wait", 200, fc);
      if (fc < 0) return;
      check("burst_strobe", out_strobe, NCHAN'(1) << order[j]);
      check("burst_chan", out_chan, order[j]);
      check("burst_i", out_data_i, vi[order[j]]);
      check("burst_q", out_data_q, vq[order[j]]);
    end
    check("burst_overrun", overrun, remask);
    pulse_clr();
    check("burst_ovr_clr", overrun, '0);
  endtask

  typedef struct {
    int chan;
    logic [WIDTH-1:0] di, dq;
    logic [NCHAN-1:0] exp_strobe;
    int exp_chan;
    logic [WIDTH-1:0] exp_i, exp_q;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int t, s, fc, sc;
    logic seen;
    logic [NCHAN-1:0] mask, remask;

    vecs[0] = '{2, 24'h123456, 24'hFEDCBA, 4'b0100, 2, 24'h123456, 24'hFEDCBA};
    vecs[1] = '{0, 24'h800000, 24'h7FFFFF, 4'b0001, 0, 24'h800000, 24'h7FFFFF};
    vecs[2] = '{3, 24'hFFFFFF, 24'h000000, 4'b1000, 3, 24'hFFFFFF, 24'h000000};
    vecs[3] = '{1, 24'h000001, 24'hA5A5A5, 4'b0010, 1, 24'h000001, 24'hA5A5A5};
    vecs[4] = '{2, 24'h7FFFFF, 24'h800000, 4'b0100, 2, 24'h7FFFFF, 24'h800000};

    do_reset(1'b1);
    @(negedge adc_clk);
    check("rst_eng_start", eng_start, 0);
    check("rst_out_strobe", out_strobe, 0);
    check("rst_out_i", out_data_i, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_eng_i", eng_data_i, 0);
    check("rst_flags", {overrun, timeout}, 0);

    // Single requests: eng_start at t+2, out_strobe two cycles after eng_done.
    eng_lat = 18;
    foreach (vecs[n]) begin
      set_data(vecs[n].chan, vecs[n].di, vecs[n].dq);
      req_strobe = NCHAN'(1) << vecs[n].chan;
      t = cyc;
      @(negedge adc_clk);
      req_strobe = '0;
      check("single_start_early", eng_start, 0);
      @(negedge adc_clk);
      check("single_start", {eng_start, 32'(cyc - t)}, {1'b1, 32'd2});
      check("single_eng_i", eng_data_i, vecs[n].di);
      check("single_eng_q", eng_data_q, vecs[n].dq);
      wait_out("single_wait", 60, fc);
      if (fc >= 0) begin
        check("single_out_lat", fc - done_cyc, 2);
        check("single_strobe", out_strobe, vecs[n].exp_strobe);
        check("single_chan", out_chan, vecs[n].exp_chan);
        check("single_out_i", out_data_i, vecs[n].exp_i);
        check("single_out_q", out_data_q, vecs[n].exp_q);
      end
    end

    // Overrun on channel 1 while channel 0 is busy; flags_clr in the same cycle loses to the set.
    do_reset(1'b1);
    set_data(0, 24'h111111, 24'h222222);
    req_strobe = 4'b0001;
    @(negedge adc_clk);
    req_strobe = '0;
    wait_start("ovr_start0", 10, sc);
    @(negedge adc_clk);
    set_data(1, 24'h000001, 24'h000001); req_strobe = 4'b0010;
    @(negedge adc_clk);
    set_data(1, 24'h000002, 24'h000002); req_strobe = 4'b0010; flags_clr = 1'b1;
    @(negedge adc_clk);
    req_strobe = '0; flags_clr = 1'b0;
    check("ovr_flag", overrun, 4'b0010);
    wait_out("ovr_wait0", 60, fc);
    check("ovr_chan0", out_chan, 0);
    wait_start("ovr_start1", 10, sc);
    check("ovr_eng_i", eng_data_i, 24'h000002);
    wait_out("ovr_wait1", 60, fc);
    check("ovr_out_i", out_data_i, 24'h000002);
    pulse_clr();
    check("ovr_clr", overrun, 0);

    // Timeout: silent engine on channel 0, then channel 1 is granted and answered.
    do_reset(1'b1);
    eng_echo = 1'b0;
    set_data(0, 24'hAAAAAA, 24'h0); set_data(1, 24'h555555, 24'h1);
    req_strobe = 4'b0011;
    @(negedge adc_clk);
    req_strobe = '0;
    wait_start("to_start0", 10, s);
    check("to_eng_i0", eng_data_i, 24'hAAAAAA);
    @(negedge adc_clk);
    eng_echo = 1'b1;
    seen = 1'b0;
    while (cyc < s + MAX_WAIT - 1) begin
      if (out_strobe != '0) seen = 1'b1;
      @(negedge adc_clk);
    end
    check("to_before", timeout, 0);
    @(negedge adc_clk);
    if (out_strobe != '0) seen = 1'b1;
    @(negedge adc_clk);
    check("to_after", timeout, 1);
    check("to_no_strobe", seen, 0);
    wait_start("to_start1", 10, sc);
    check("to_eng_i1", eng_data_i, 24'h555555);
    wait_out("to_wait1", 60, fc);
    check("to_chan1", out_chan, 1);
    pulse_clr();
    check("to_clr", timeout, 0);

    // Reset pulse during WAIT, with the engine answering afterwards.
    do_reset(1'b1);
    eng_lat = 20;
    set_data(2, 24'h0F0F0F, 24'hF0F0F0);
    req_strobe = 4'b0100;
    @(negedge adc_clk);
    req_strobe = '0;
    wait_start("rstw_start", 10, sc);
    repeat (5) @(negedge adc_clk);
    reset = 1'b1;
    @(negedge adc_clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge adc_clk);
      if (out_strobe != '0 || eng_start) seen = 1'b1;
    end
    check("rstw_quiet", seen, 0);
    check("rstw_outs", {out_data_i, out_data_q, out_chan, eng_data_i, overrun, timeout}, 0);

    // enable=0 during WAIT drops the result and the pending channel 2.
    do_reset(1'b1);
    set_data(1, 24'h010101, 24'h0); set_data(2, 24'h020202, 24'h0);
    req_strobe = 4'b0110;
    @(negedge adc_clk);
    req_strobe = '0;
    wait_start("en_start", 10, sc);
    check("en_eng_i", eng_data_i, 24'h010101);
    repeat (3) @(negedge adc_clk);
    enable = 1'b0;
    repeat (2) @(negedge adc_clk);
    enable = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge adc_clk);
      if (out_strobe != '0 || eng_start) seen = 1'b1;
    end
    check("en_quiet", seen, 0);

    // Strobe on channel 3 in its own ISSUE cycle: re-pends without overrun.
    do_reset(1'b1);
    eng_lat = 10;
    set_data(3, 24'h333333, 24'h444444);
    req_strobe = 4'b1000;
    @(negedge adc_clk);
    req_strobe = '0;
    wait_start("iss_start0", 10, sc);
    check("iss_eng_i0", eng_data_i, 24'h333333);
    set_data(3, 24'h555555, 24'h666666);
    req_strobe = 4'b1000;
    @(negedge adc_clk);
    req_strobe = '0;
    wait_out("iss_wait0", 60, fc);
    check("iss_out0", {out_strobe, out_data_i}, {4'b1000, 24'h333333});
    wait_start("iss_start1", 10, sc);
    check("iss_eng_i1", eng_data_i, 24'h555555);
    wait_out("iss_wait1", 60, fc);
    check("iss_out1", {out_strobe, out_data_i, out_data_q}, {4'b1000, 24'h555555, 24'h666666});
    check("iss_overrun", overrun, 0);

    // Round robin with all channels, then randomized bursts against the model.
    do_reset(1'b1);
    rr_last = NCHAN - 1;
    run_burst(4'b1111, 4'b0000, 18);
    for (int r = 0; r < 25; r++) begin
      mask = NCHAN'($urandom_range(1, (1 << NCHAN) - 1));
      remask = ($urandom_range(0, 2) == 0) ? (mask & NCHAN'($urandom)) : '0;
      run_burst(mask, remask, $urandom_range(1, 40));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_iq_sched.md
Name: fir_iq_sched

Overview:
- Round-robin scheduler that shares one sequential I/Q FIR MAC engine (17-tap, one tap per adc_clk) among NCHAN receiver channels.
- Each channel presents a sample with a strobe. The scheduler holds the sample, grants the engine to one channel at a time, then routes the filtered result back to that channel with a one-hot strobe.
- It sits between the per-channel CIC/decimator outputs and the shared FIR engine in the rx path.
- It reports overrun and engine-timeout conditions as sticky flags.

Parameters:
- NCHAN, 4, number of requesting channels (2..8)
- WIDTH, 24, I/Q sample width in bits
- MAX_WAIT, 64, adc_clk cycles allowed between eng_start and eng_done before abort

Ports:
- adc_clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  scheduler enable; 0 flushes all pending requests
- req_strobe  in  NCHAN  per-channel one-cycle sample-valid pulse
- req_data_i  in  NCHAN*WIDTH  flattened signed I samples; channel c occupies bits [c*WIDTH +: WIDTH]
- req_data_q  in  NCHAN*WIDTH  flattened signed Q samples, same packing
- eng_start  out  1  one-cycle start pulse to the FIR engine
- eng_data_i  out  WIDTH  I sample to the engine, valid while eng_start=1
- eng_data_q  out  WIDTH  Q sample to the engine, valid while eng_start=1
- eng_done  in  1  one-cycle engine result-valid pulse
- eng_res_i  in  WIDTH  engine I result, valid with eng_done
- eng_res_q  in  WIDTH  engine Q result, valid with eng_done
- out_strobe  out  NCHAN  one-hot result-valid, one cycle
- out_data_i  out  WIDTH  filtered I result
- out_data_q  out  WIDTH  filtered Q result
- out_chan  out  $clog2(NCHAN)  index of the channel receiving the result
- overrun  out  NCHAN  sticky: channel strobed while its sample was still pending
- timeout  out  1  sticky: engine failed to answer within MAX_WAIT
- flags_clr  in  1  clears overrun and timeout

Behaviour:
- Reset (synchronous, active-high, adc_clk):
  - Outputs: eng_start=0, out_strobe=0, out_data_i/q=0, out_chan=0, eng_data_i/q=0, overrun=0, timeout=0.
  - Internal: state=IDLE, pending=0, last_grant=NCHAN-1.
  - Reset asserted mid-operation aborts the current grant; a later eng_done is ignored because the state is IDLE.
- Capture:
  - req_strobe[c] latches channel c's I/Q into hold[c] and sets pending[c] on the next edge.
  - If pending[c] is already set, the new sample overwrites hold[c] and overrun[c] is set.
- State machine:
  - IDLE: if enable=1 and pending!=0, grant the channel found by round-robin search starting at last_grant+1 (mod NCHAN). Record grant and last_grant, go to ISSUE.
  - ISSUE: eng_start=1 for exactly one cycle with eng_data_i/q=hold[grant]. Clear pending[grant], zero the wait counter, go to WAIT.
  - WAIT: increment the wait counter each cycle.
    - On eng_done, register eng_res_i/q into out_data_i/q and set out_chan=grant, then go to DELIVER.
    - If the counter reaches MAX_WAIT without eng_done, set timeout, drop the sample with no out_strobe, and go to IDLE.
  - DELIVER: out_strobe=1<<grant for one cycle, then go to IDLE.
- Simultaneous events:
  - req_strobe[grant] in the ISSUE cycle: the set wins, so pending stays 1 with the new sample. No overrun, because the old sample was already consumed.
  - eng_done in any state other than WAIT is ignored.
  - flags_clr in the same cycle as a new overrun/timeout event: the set wins.
- enable=0: clears pending on every cycle and forces IDLE from ISSUE/WAIT/DELIVER; hold registers keep their values and flags are untouched. Any result in flight is discarded.
- Latency: req_strobe at cycle t gives eng_start at t+2 (idle scheduler). eng_done at cycle u gives out_strobe at u+2 (u+1 register into DELIVER, asserted in DELIVER).
- Fairness: with all channels continuously pending, grants rotate 0,1,..,NCHAN-1,0. A channel never waits more than NCHAN-1 other grants.
- Widths: data passes through unmodified; no arithmetic beyond the wait counter, which is $clog2(MAX_WAIT+1) bits and saturates.

Decomposition:
- Package fir_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, DELIVER}
  - NCHAN_MAX=8
  - function returning next round-robin index from a pending mask and last_grant
- Sub-module rr_arbiter (NCHAN): pending mask + last_grant in, grant index + grant_valid out, purely combinational.
- Hold registers and the FSM stay in fir_iq_sched.

Test Plan:
- Single request: NCHAN=4; req_strobe[2] with I=0x123456, Q=0xFEDCBA; engine model echoes the input after 18 cycles. Expect eng_start 2 cycles after the strobe with the same data, then out_strobe=4'b0100, out_chan=2, data echoed.
- Round robin: all four channels strobed in the same cycle. Expect grants in order 0,1,2,3 and four out_strobes in that order, with no overrun.
- Overrun: strobe channel 1 twice while channel 0 is busy, second sample 0x000002. Expect overrun=4'b0010 and the engine to receive 0x000002. flags_clr then reads back 0.
- Timeout: engine model never asserts eng_done. Expect timeout=1 at eng_start+MAX_WAIT, no out_strobe, and the next pending channel granted.
- Reset/enable mid-operation: reset pulse during WAIT, followed by a late eng_done. Expect no out_strobe and all outputs 0. Repeat with enable=0 during WAIT: expect pending cleared and IDLE.
- Same-cycle strobe at ISSUE: req_strobe[3] coincides with its own ISSUE cycle. Expect pending[3]=1 afterwards, overrun[3]=0, and a second grant of channel 3.
